store_buffer_fwd: RTL

STORE_BUFFER_FWD -- requirements
Module: store_buffer_fwd

---
 rtl/store_buffer_fwd.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/store_buffer_fwd.sv
// store_buffer_fwd
//   Two-stage store buffer. Stores first enter the speculative queue. commit_i
//   moves the oldest speculative store to the commit queue, and the commit
//   queue drains to memory. Loads look up both queues combinationally and get
//   byte-wise forwarded data, taking the youngest store for each lane.
//
//   Optional build macro: STORE_BUFFER_COALESCE_EN. When it is defined, a
//   committed store to the same word as the commit-queue tail is merged into
//   that tail instead of allocating a new entry.
//
// Ports
//   clk_i, rst_ni                   clock, async active-low reset
//   flush_i                         drop all speculative stores
//   st_valid_i/st_ready_o           store input (paddr, data, be, size)
//   commit_i/commit_ready_o         retire oldest speculative store
//   ld_valid_i, ld_paddr_i, ld_be_i load lookup
//   fwd_hit_o/fwd_data_o            full forward and its data
//   fwd_conflict_o                  partial overlap, load must retry
//   no_st_pending_o, empty_o        queue status
//   drain_stall_i                   hold off memory writes
//   mem_req_o/mem_gnt_i             memory write handshake
//   mem_addr_o/mem_data_o/mem_be_o/mem_size_o  memory write payload
module store_buffer_fwd #(
    parameter int SPEC_DEPTH   = 8,
    parameter int COMMIT_DEPTH = 8,
    parameter int DATA_W       = 64,
    parameter int PADDR_W      = 56
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  st_valid_i,
    output logic                  st_ready_o,
    input  logic [PADDR_W-1:0]    st_paddr_i,
    input  logic [DATA_W-1:0]     st_data_i,
    input  logic [DATA_W/8-1:0]   st_be_i,
    input  logic [1:0]            st_size_i,
    input  logic                  commit_i,
    output logic                  commit_ready_o,
    input  logic                  ld_valid_i,
    input  logic [PADDR_W-1:0]    ld_paddr_i,
    input  logic [DATA_W/8-1:0]   ld_be_i,
    output logic                  fwd_hit_o,
    output logic [DATA_W-1:0]     fwd_data_o,
    output logic                  fwd_conflict_o,
    output logic                  no_st_pending_o,
    output logic                  empty_o,
    input  logic                  drain_stall_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [PADDR_W-1:0]    mem_addr_o,
    output logic [DATA_W-1:0]     mem_data_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    output logic [1:0]            mem_size_o
);

    localparam int BE_W = DATA_W / 8;
    localparam int OFF  = (BE_W > 1) ? $clog2(BE_W) : 0;
    localparam int SAW  = $clog2(SPEC_DEPTH);
    localparam int CAW  = $clog2(COMMIT_DEPTH);
    localparam int SCW  = SAW + 1;
    localparam int CCW  = CAW + 1;

    // ---------------- speculative queue ----------------
    logic [PADDR_W-1:0] s_addr [SPEC_DEPTH];
    logic [DATA_W-1:0]  s_data [SPEC_DEPTH];
    logic [BE_W-1:0]    s_be   [SPEC_DEPTH];
    logic [1:0]         s_size [SPEC_DEPTH];
    logic [SAW-1:0]     s_wptr, s_rptr, s_rptr_next;
    logic [SCW-1:0]     s_count;
    logic               st_fire;

    // ---------------- commit queue ----------------
    logic [PADDR_W-1:0] c_addr [COMMIT_DEPTH];
    logic [DATA_W-1:0]  c_data [COMMIT_DEPTH];
    logic [BE_W-1:0]    c_be   [COMMIT_DEPTH];
    logic [1:0]         c_size [COMMIT_DEPTH];
    logic [CAW-1:0]     c_head, c_tail, c_last;
    logic [CCW-1:0]     c_count;
    logic               merge, alloc, grant;

    assign st_ready_o     = (s_count < SCW'(SPEC_DEPTH)) || commit_i;
    assign st_fire        = st_valid_i && st_ready_o && !flush_i;
    assign s_rptr_next    = commit_i ? s_rptr + 1'b1 : s_rptr;

    assign commit_ready_o = (c_count < CCW'(COMMIT_DEPTH));
    assign c_last         = c_tail - 1'b1;
    assign mem_req_o      = (c_count != '0) && !drain_stall_i;
    assign grant          = mem_req_o && mem_gnt_i;

`ifdef STORE_BUFFER_COALESCE_EN
    // A single-entry queue whose head is being requested is left alone so the
    // pending write payload stays stable until it is granted.
    assign merge = commit_i && (c_count != '0)
                && (c_addr[c_last][PADDR_W-1:OFF] == s_addr[s_rptr][PADDR_W-1:OFF])
                && !((c_count == CCW'(1)) && mem_req_o);
`else
    assign merge = 1'b0;
`endif
    assign alloc = commit_i && !merge;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_wptr  <= '0;
            s_rptr  <= '0;
            s_count <= '0;
        end else begin
            s_rptr <= s_rptr_next;
            if (flush_i) begin
                // Realign write pointer with the read pointer after this commit.
                s_wptr  <= s_rptr_next;
                s_count <= '0;
            end else begin
                if (st_fire)
                    s_wptr <= s_wptr + 1'b1;
                case ({st_fire, commit_i})
                    2'b10:   s_count <= s_count + 1'b1;
                    2'b01:   s_count <= s_count - 1'b1;
                    default: s_count <= s_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (st_fire) begin
            s_addr[s_wptr] <= st_paddr_i;
            s_data[s_wptr] <= st_data_i;
            s_be[s_wptr]   <= st_be_i;
            s_size[s_wptr] <= st_size_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_head  <= '0;
            c_tail  <= '0;
            c_count <= '0;
        end else begin
            if (grant)
                c_head <= c_head + 1'b1;
            if (alloc)
                c_tail <= c_tail + 1'b1;
            case ({alloc, grant})
                2'b10:   c_count <= c_count + 1'b1;
                2'b01:   c_count <= c_count - 1'b1;
                default: c_count <= c_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (alloc) begin
            c_addr[c_tail] <= s_addr[s_rptr];
            c_data[c_tail] <= s_data[s_rptr];
            c_be[c_tail]   <= s_be[s_rptr];
            c_size[c_tail] <= s_size[s_rptr];
        end
        if (merge) begin
            for (int b = 0; b < BE_W; b++) begin
                if (s_be[s_rptr][b])
                    c_data[c_last][8*b +: 8] <= s_data[s_rptr][8*b +: 8];
            end
            c_be[c_last]   <= c_be[c_last] | s_be[s_rptr];
            c_size[c_last] <= 2'd3;
        end
    end

    assign mem_addr_o = c_addr[c_head];
    assign mem_data_o = c_data[c_head];
    assign mem_be_o   = c_be[c_head];
    assign mem_size_o = c_size[c_head];

    assign no_st_pending_o = (c_count == '0);
    assign empty_o         = no_st_pending_o && (s_count == '0);

    // ---------------- load forwarding ----------------
    // Walk entries oldest to youngest so later matches overwrite earlier lanes.
    logic [DATA_W-1:0] fwd_bytes;
    logic [BE_W-1:0]   covered, ld_cov;

    always_comb begin
        fwd_bytes = '0;
        covered   = '0;
        for (int i = 0; i < COMMIT_DEPTH; i++) begin
            if ((CCW'(i) < c_count) &&
                (c_addr[c_head + CAW'(i)][PADDR_W-1:OFF] == ld_paddr_i[PADDR_W-1:OFF])) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (c_be[c_head + CAW'(i)][b]) begin
                        fwd_bytes[8*b +: 8] = c_data[c_head + CAW'(i)][8*b +: 8];
                        covered[b]          = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < SPEC_DEPTH; i++) begin
            if ((SCW'(i) < s_count) &&
                (s_addr[s_rptr + SAW'(i)][PADDR_W-1:OFF] == ld_paddr_i[PADDR_W-1:OFF])) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (s_be[s_rptr + SAW'(i)][b]) begin
                        fwd_bytes[8*b +: 8] = s_data[s_rptr + SAW'(i)][8*b +: 8];
                        covered[b]          = 1'b1;
                    end
                end
            end
        end
    end

    assign ld_cov         = covered & ld_be_i;
    assign fwd_hit_o      = ld_valid_i && (ld_be_i != '0) && (ld_cov == ld_be_i);
    assign fwd_conflict_o = ld_valid_i && (ld_cov != '0) && (ld_cov != ld_be_i);
    assign fwd_data_o     = (fwd_hit_o || fwd_conflict_o) ? fwd_bytes : '0;

    generate
        if (OFF > 0) begin : g_ld_offset
            logic unused_ld_offset;
            assign unused_ld_offset = ^ld_paddr_i[OFF-1:0];
        end
    endgenerate

    commit_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        commit_i |-> ((s_count != '0) && commit_ready_o));

endmodule
